// File: rtl/pio_host_seq.sv
// pio_host_seq: host-side sequencer for the PIO host port.
// Streams the program image into instruction memory, replays the config
// list, then feeds a valid/ready byte stream into one SM's TX FIFO,
// pushing at most once every PACE cycles while that FIFO is not full.
module pio_host_seq #(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 5,
  parameter int PACE     = 4096,
  parameter int SM       = 0
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  conf_addr,
  input  logic [35:0] conf_data,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic [3:0]  tx_full,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [31:0] din,
  output logic [1:0]  mindex,
  output logic        load_done,
  output logic [7:0]  stalled
);

  localparam int            PW    = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [4:0]    PLAST = 5'(PROG_LEN - 1);
  localparam logic [4:0]    CLEN  = 5'(CONF_LEN);
  localparam logic [PW-1:0] PMAX  = PW'(PACE - 1);
  localparam logic [3:0]    SMSEL = 4'(1 << SM);

  typedef enum logic [1:0] {S_LOAD, S_CONF, S_RUN} state_t;

  state_t        r_state;
  logic [4:0]    r_pindex;
  logic [4:0]    r_cindex;
  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_action;
  logic [4:0]    r_index;
  logic [31:0]   r_din;
  logic          r_load_done;
  logic [7:0]    r_stalled;

  logic w_opp;
  logic w_full;
  logic w_hs;

  // Push opportunity once per PACE cycles in RUN; only our SM's full flag
  // matters (masking keeps the other flags out of the decision).
  assign w_opp  = (r_state == S_RUN) && (r_pcnt == '0);
  assign w_full = |(tx_full & SMSEL);
  assign w_hs   = s_valid && s_ready;

  assign s_ready   = w_opp && !w_full;
  assign prog_addr = r_pindex;
  assign conf_addr = r_cindex;
  assign mindex    = 2'(SM);
  assign action    = r_action;
  assign index     = r_index;
  assign din       = r_din;
  assign load_done = r_load_done;
  assign stalled   = r_stalled;

  // Sequencer: LOAD -> CONF -> RUN with all host-port outputs registered.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_pindex    <= '0;
      r_cindex    <= '0;
      r_pcnt      <= '0;
      r_action    <= '0;
      r_index     <= '0;
      r_din       <= '0;
      r_load_done <= 1'b0;
      r_stalled   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_action <= 4'd1;
          r_index  <= r_pindex;
          r_din    <= {16'h0, prog_data};
          r_pindex <= r_pindex + 5'd1;
          if (r_pindex == PLAST) r_state <= S_CONF;
        end
        S_CONF: begin
          r_index <= '0;
          if (r_cindex == CLEN) begin
            // Trailing NOP cycle; din keeps the last config data.
            r_action    <= 4'd0;
            r_load_done <= 1'b1;
            r_state     <= S_RUN;
          end else begin
            r_action <= conf_data[35:32];
            r_din    <= conf_data[31:0];
            r_cindex <= r_cindex + 5'd1;
          end
        end
        S_RUN: begin
          r_pcnt <= (r_pcnt == PMAX) ? '0 : r_pcnt + PW'(1);
          if (w_hs) begin
            r_action <= 4'd4;
            r_din    <= {24'h0, s_data};
          end else begin
            r_action <= 4'd0;
          end
          if (w_opp && s_valid && w_full && r_stalled != 8'hFF)
            r_stalled <= r_stalled + 8'd1;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_host_seq.sv
// tb_pio_host_seq: table-driven load/config checks plus a push scoreboard
// for the RUN phase (pacing, backpressure, saturation, reset mid-push).
module tb_pio_host_seq;
  localparam int PROG_LEN = 32;
  localparam int CONF_LEN = 5;
  localparam int PACE     = 8;
  localparam int SM       = 1;
  localparam int NVEC     = PROG_LEN + CONF_LEN + 1;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  prog_addr, conf_addr;
  logic [15:0] prog_data;
  logic [35:0] conf_data;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic [3:0]  tx_full = 4'h0;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [31:0] din;
  logic [1:0]  mindex;
  logic        load_done;
  logic [7:0]  stalled;

  pio_host_seq #(.PROG_LEN(PROG_LEN), .CONF_LEN(CONF_LEN), .PACE(PACE), .SM(SM)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .conf_addr(conf_addr), .conf_data(conf_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .tx_full(tx_full),
    .action(action), .index(index), .din(din), .mindex(mindex),
    .load_done(load_done), .stalled(stalled)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Asynchronous-read ROMs
  assign prog_data = 16'hA000 + 16'(prog_addr);
  assign conf_data = {4'h2 + 4'(conf_addr), 32'h100 + 32'(conf_addr)};

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        ld;
    logic        rdy;
  } vec_t;

  vec_t        tbl[NVEC];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb[$];
  int          push_rc[$];
  int          rc;
  logic [7:0]  st_m;
  logic [31:0] din_m;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Release reset and walk the load/config table, one cycle per entry.
  task automatic run_load_tbl();
    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_25mhz);
      #1;
      chk($sformatf("ld%0d_action", i), 32'(action), 32'(tbl[i].act));
      chk($sformatf("ld%0d_index", i), 32'(index), 32'(tbl[i].idx));
      chk($sformatf("ld%0d_din", i), din, tbl[i].dat);
      chk($sformatf("ld%0d_load_done", i), 32'(load_done), 32'(tbl[i].ld));
      chk($sformatf("ld%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
    end
    rc = 0;
    st_m = 8'd0;
    din_m = 32'h104;
  endtask

  // One RUN cycle: predict handshake/stall, clock, then check the outputs.
  task automatic cyc(output logic hs, output logic opp);
    logic [7:0] b;
    #1;
    opp = (rc % PACE) == 0;
    chk("s_ready", 32'(s_ready), 32'(opp && !tx_full[SM]));
    hs = s_valid && opp && !tx_full[SM];
    if (hs) sb.push_back(s_data);
    if (opp && s_valid && tx_full[SM] && st_m != 8'hFF) st_m = st_m + 8'd1;
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    rc++;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        b = sb.pop_front();
        din_m = {24'h0, b};
        push_rc.push_back(rc);
      end
      chk("push_action", 32'(action), 32'd4);
    end else begin
      chk("idle_action", 32'(action), 32'd0);
    end
    chk("din", din, din_m);
    chk("stalled", 32'(stalled), 32'(st_m));
  endtask

  initial begin
    logic       hs, opp;
    logic [7:0] bytes [3];
    int         bi, guard, nopp;

    for (int i = 0; i < NVEC; i++) begin
      if (i < PROG_LEN)
        tbl[i] = '{act: 4'd1, idx: 5'(i), dat: 32'hA000 + 32'(i), ld: 1'b0, rdy: 1'b0};
      else if (i < PROG_LEN + CONF_LEN)
        tbl[i] = '{act: 4'(2 + i - PROG_LEN), idx: 5'd0, dat: 32'h100 + 32'(i - PROG_LEN),
                   ld: 1'b0, rdy: 1'b0};
      else
        tbl[i] = '{act: 4'd0, idx: 5'd0, dat: 32'h104, ld: 1'b1, rdy: 1'b1};
    end
    bytes[0] = 8'h48; bytes[1] = 8'h65; bytes[2] = 8'h6C;

    // Reset state
    repeat (3) @(negedge clk_25mhz);
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_stalled", 32'(stalled), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_conf_addr", 32'(conf_addr), 32'd0);
    chk("mindex", 32'(mindex), 32'(SM));

    run_load_tbl();

    // Pacing: three bytes, pulses PACE apart
    s_valid = 1'b1; bi = 0; s_data = bytes[0]; guard = 0;
    while (bi < 3 && guard < 100) begin
      cyc(hs, opp);
      if (hs) begin
        bi++;
        if (bi < 3) s_data = bytes[bi]; else s_valid = 1'b0;
      end
      guard++;
    end
    chk("pace_timeout", 32'(bi), 32'd3);
    cyc(hs, opp);
    if (push_rc.size() >= 3) begin
      chk("pace_gap0", 32'(push_rc[1] - push_rc[0]), 32'(PACE));
      chk("pace_gap1", 32'(push_rc[2] - push_rc[1]), 32'(PACE));
    end else begin
      chk("pace_pushes", 32'(push_rc.size()), 32'd3);
    end

    // Backpressure: three blocked opportunities, then release
    s_valid = 1'b1; s_data = 8'h5A; tx_full = 4'(1 << SM); nopp = 0; guard = 0;
    while (nopp < 3 && guard < 100) begin
      cyc(hs, opp);
      if (opp) nopp++;
      guard++;
    end
    chk("bp_stalled3", 32'(stalled), 32'd3);
    // No counting while s_valid is low
    s_valid = 1'b0;
    repeat (2 * PACE) cyc(hs, opp);
    chk("bp_novalid", 32'(stalled), 32'd3);
    s_valid = 1'b1; tx_full = 4'h0; guard = 0; hs = 1'b0;
    while (!hs && guard < 100) begin cyc(hs, opp); guard++; end
    chk("bp_release_push", 32'(hs), 32'd1);
    s_valid = 1'b0;
    cyc(hs, opp);

    // Other SMs' full flags ignored
    tx_full = ~4'(1 << SM); s_valid = 1'b1; s_data = 8'h33; guard = 0; hs = 1'b0;
    while (!hs && guard < 100) begin cyc(hs, opp); guard++; end
    chk("other_full_push", 32'(hs), 32'd1);
    chk("other_full_stalled", 32'(stalled), 32'd3);
    s_valid = 1'b0;
    cyc(hs, opp);

    // Saturation: 300 blocked opportunities
    tx_full = 4'(1 << SM); s_valid = 1'b1; nopp = 0; guard = 0;
    while (nopp < 300 && guard < 5000) begin
      cyc(hs, opp);
      if (opp) nopp++;
      guard++;
    end
    chk("sat_stalled", 32'(stalled), 32'd255);

    // Reset asserted in a handshake cycle
    tx_full = 4'h0; s_valid = 1'b1; s_data = 8'h77; guard = 0;
    while ((rc % PACE) != 0 && guard < 100) begin cyc(hs, opp); guard++; end
    reset = 1'b1;
    #1;
    chk("rstrun_hs_ready", 32'(s_ready), 32'd1);
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    chk("rstrun_action", 32'(action), 32'd0);
    chk("rstrun_load_done", 32'(load_done), 32'd0);
    chk("rstrun_stalled", 32'(stalled), 32'd0);
    chk("rstrun_din", din, 32'd0);
    chk("rstrun_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    sb.delete();
    run_load_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired want finished");
    $fatal(1, "timeout");
  end
endmodule
